// File: rtl/dmem_ctrl.sv
// Byte-laned data memory behind the core's data port: combinational loads with
// sign/zero extension, sticky error capture, committed-store counter.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_wr_en,
    input  logic                 d_rd_en,
    input  logic [31:0]          dAddr,
    input  logic [31:0]          dWdata,
    input  logic [1:0]           store_size,
    input  logic [1:0]           load_size,
    input  logic                 load_uns,
    output logic [31:0]          dRdata,
    output logic                 err_flag,
    output logic [31:0]          err_addr,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] wr_count
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic                  st_mis, ld_mis, st_err, ld_err, st_ok, ld_ok, any_err;
    logic [3:0]            wr_be;
    logic [31:0]           wr_lanes;
    logic                  unused_addr_bits;

    // Upper address bits alias onto the same words.
    assign word_idx         = dAddr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^dAddr[31:ADDR_WIDTH+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign st_mis = ((store_size == SZ_HALF) && dAddr[0]) ||
                    ((store_size == SZ_WORD) && (dAddr[1:0] != 2'b00));
    assign ld_mis = ((load_size == SZ_HALF) && dAddr[0]) ||
                    ((load_size == SZ_WORD) && (dAddr[1:0] != 2'b00));
`else
    assign st_mis = 1'b0;
    assign ld_mis = 1'b0;
`endif

    assign st_err  = d_wr_en && ((store_size == SZ_ILL) || st_mis);
    assign ld_err  = d_rd_en && ((load_size == SZ_ILL) || ld_mis);
    assign st_ok   = d_wr_en && !st_err;
    assign ld_ok   = d_rd_en && !ld_err;
    assign any_err = st_err || ld_err;

    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = dWdata;
        case (store_size)
            SZ_BYTE: begin
                wr_be    = 4'b0001 << dAddr[1:0];
                wr_lanes = {4{dWdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be    = dAddr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{dWdata[15:0]}};
            end
            SZ_WORD: wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // Contents are deliberately not reset; the rst gate only blocks writes while in reset.
    always_ff @(posedge clk) begin
        if (rst && st_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[word_idx];

    always_comb begin
        case (dAddr[1:0])
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = dAddr[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        dRdata = 32'h0;
        if (ld_ok) begin
            case (load_size)
                SZ_BYTE: dRdata = load_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                SZ_HALF: dRdata = load_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
                SZ_WORD: dRdata = rd_word;
                default: dRdata = 32'h0;
            endcase
        end
    end

    // A new error outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag <= 1'b0;
            err_addr <= 32'h0;
        end else if (any_err && (!err_flag || err_clr)) begin
            err_flag <= 1'b1;
            err_addr <= dAddr;
        end else if (err_clr && !any_err) begin
            err_flag <= 1'b0;
            err_addr <= 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= '0;
        end else if (st_ok) begin
            wr_count <= wr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed, table-driven bench for dmem_ctrl (built with CNT_WIDTH=4 to reach the wrap).
module tb_dmem_ctrl;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        d_wr_en = 1'b0, d_rd_en = 1'b0, load_uns = 1'b0, err_clr = 1'b0;
    logic [31:0] dAddr = 32'h0, dWdata = 32'h0;
    logic [1:0]  store_size = 2'b10, load_size = 2'b10;
    logic [31:0] dRdata, err_addr;
    logic        err_flag;
    logic [3:0]  wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_ctrl #(.ADDR_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .d_wr_en(d_wr_en), .d_rd_en(d_rd_en),
        .dAddr(dAddr), .dWdata(dWdata), .store_size(store_size),
        .load_size(load_size), .load_uns(load_uns), .dRdata(dRdata),
        .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr, rd;
        logic [31:0] addr, wdata;
        logic [1:0]  ss, ls;
        logic        uns, clr;
        logic [31:0] exp_rd;
        logic        exp_flag;
        logic [31:0] exp_eaddr;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] ss, input logic [1:0] ls,
                       input logic uns, input logic clr, input logic [31:0] exp_rd,
                       input logic exp_flag, input logic [31:0] exp_eaddr, input logic [3:0] exp_cnt);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.ss = ss; v.ls = ls;
        v.uns = uns; v.clr = clr; v.exp_rd = exp_rd; v.exp_flag = exp_flag;
        v.exp_eaddr = exp_eaddr; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endtask

    task automatic idle();
        d_wr_en = 1'b0; d_rd_en = 1'b0; err_clr = 1'b0; load_uns = 1'b0;
        store_size = 2'b10; load_size = 2'b10; dAddr = 32'h0; dWdata = 32'h0;
    endtask

    task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        idle();
        d_wr_en = 1'b1; dAddr = addr; dWdata = data;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] ea;
        logic [31:0] misld;

        // Reset, then one store so the in-reset store below has something to disturb.
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_flag", {31'h0, err_flag}, 32'h0);
        chk("rst_eaddr", err_addr, 32'h0);
        chk("rst_cnt", {28'h0, wr_count}, 32'h0);
        store_word(32'h10, 32'h12345678);
        chk("pre_cnt", {28'h0, wr_count}, 32'h1);

        // Store attempted while reset is held must be ignored.
        @(negedge clk);
        rst = 1'b0;
        d_wr_en = 1'b1; dAddr = 32'h10; dWdata = 32'hDEADBEEF;
        #1;
        chk("inrst_cnt", {28'h0, wr_count}, 32'h0);
        chk("inrst_flag", {31'h0, err_flag}, 32'h0);
        @(posedge clk);
        #1;
        chk("inrst_cnt_edge", {28'h0, wr_count}, 32'h0);
        chk("inrst_eaddr_edge", err_addr, 32'h0);
        @(negedge clk);
        idle();
        rst = 1'b1;

        // wr rd addr wdata ss ls uns clr | exp_rd flag eaddr cnt
        add(0, 1, 32'h10, 32'h0,        2'b10, 2'b10, 0, 0, 32'h12345678, 0, 32'h0, 4'd0);
        add(1, 0, 32'h20, 32'h11223344, 2'b10, 2'b10, 0, 0, 32'h0,        0, 32'h0, 4'd1);
        add(1, 0, 32'h21, 32'h555555AA, 2'b00, 2'b10, 0, 0, 32'h0,        0, 32'h0, 4'd2);
        add(0, 1, 32'h20, 32'h0,        2'b10, 2'b10, 0, 0, 32'h1122AA44, 0, 32'h0, 4'd2);
        add(0, 1, 32'h21, 32'h0,        2'b10, 2'b00, 0, 0, 32'hFFFFFFAA, 0, 32'h0, 4'd2);
        add(0, 1, 32'h21, 32'h0,        2'b10, 2'b00, 1, 0, 32'h000000AA, 0, 32'h0, 4'd2);
        add(0, 1, 32'h22, 32'h0,        2'b10, 2'b01, 0, 0, 32'h00001122, 0, 32'h0, 4'd2);
        add(1, 0, 32'h24, 32'h01020304, 2'b10, 2'b10, 0, 0, 32'h0,        0, 32'h0, 4'd3);
        add(1, 0, 32'h26, 32'hFFFF8001, 2'b01, 2'b10, 0, 0, 32'h0,        0, 32'h0, 4'd4);
        add(0, 1, 32'h26, 32'h0,        2'b10, 2'b01, 0, 0, 32'hFFFF8001, 0, 32'h0, 4'd4);
        add(0, 1, 32'h26, 32'h0,        2'b10, 2'b01, 1, 0, 32'h00008001, 0, 32'h0, 4'd4);
        add(0, 1, 32'h24, 32'h0,        2'b10, 2'b10, 1, 0, 32'h80010304, 0, 32'h0, 4'd4);
        add(0, 1, 32'h25, 32'h0,        2'b10, 2'b00, 0, 0, 32'h00000003, 0, 32'h0, 4'd4);
        add(0, 1, 32'h27, 32'h0,        2'b10, 2'b00, 0, 0, 32'hFFFFFF80, 0, 32'h0, 4'd4);
        add(0, 0, 32'h24, 32'h0,        2'b10, 2'b10, 0, 0, 32'h0,        0, 32'h0, 4'd4);
        // Read-during-write returns the old word.
        add(1, 0, 32'h30, 32'h0,        2'b10, 2'b10, 0, 0, 32'h0,        0, 32'h0, 4'd5);
        add(1, 1, 32'h30, 32'h55,       2'b10, 2'b10, 0, 0, 32'h0,        0, 32'h0, 4'd6);
        add(0, 1, 32'h30, 32'h0,        2'b10, 2'b10, 0, 0, 32'h55,       0, 32'h0, 4'd6);
        // Misalignment.
        add(1, 0, 32'h40, 32'h0BADC0DE, 2'b10, 2'b10, 0, 0, 32'h0,        0, 32'h0, 4'd7);
        add(1, 0, 32'h44, 32'h00007FFE, 2'b10, 2'b10, 0, 0, 32'h0,        0, 32'h0, 4'd8);
        c     = TRAP ? 4'd8 : 4'd9;
        ea    = TRAP ? 32'h42 : 32'h0;
        misld = TRAP ? 32'h0 : 32'h00007FFE;
        add(1, 0, 32'h42, 32'hCAFEF00D, 2'b10, 2'b10, 0, 0, 32'h0,        TRAP, ea, c);
        add(0, 1, 32'h45, 32'h0,        2'b10, 2'b01, 0, 0, misld,        TRAP, ea, c);
        add(0, 1, 32'h40, 32'h0,        2'b10, 2'b10, 0, 0, TRAP ? 32'h0BADC0DE : 32'hCAFEF00D, TRAP, ea, c);
        // Illegal store size: no write, no count, error captured (unless already sticky).
        ea = TRAP ? 32'h42 : 32'h40;
        add(1, 0, 32'h40, 32'hFFFFFFFF, 2'b11, 2'b10, 0, 0, 32'h0,        1, ea, c);
        add(0, 1, 32'h40, 32'h0,        2'b10, 2'b10, 0, 0, TRAP ? 32'h0BADC0DE : 32'hCAFEF00D, 1, ea, c);
        // Clear and clear-vs-error priority.
        add(0, 0, 32'h0,  32'h0,        2'b10, 2'b10, 0, 1, 32'h0,        0, 32'h0, c);
        add(0, 1, 32'h7C, 32'h0,        2'b10, 2'b11, 0, 1, 32'h0,        1, 32'h7C, c);
        add(0, 1, 32'h60, 32'h0,        2'b10, 2'b11, 0, 0, 32'h0,        1, 32'h7C, c);
        add(0, 0, 32'h0,  32'h0,        2'b10, 2'b10, 0, 1, 32'h0,        0, 32'h0, c);
        add(1, 1, 32'h68, 32'h12345678, 2'b11, 2'b11, 0, 0, 32'h0,        1, 32'h68, c);
        add(0, 0, 32'h0,  32'h0,        2'b10, 2'b10, 0, 1, 32'h0,        0, 32'h0, c);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            d_wr_en = vecs[i].wr; d_rd_en = vecs[i].rd; dAddr = vecs[i].addr;
            dWdata = vecs[i].wdata; store_size = vecs[i].ss; load_size = vecs[i].ls;
            load_uns = vecs[i].uns; err_clr = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_rdata", i), dRdata, vecs[i].exp_rd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_flag", i), {31'h0, err_flag}, {31'h0, vecs[i].exp_flag});
            chk($sformatf("v%0d_eaddr", i), err_addr, vecs[i].exp_eaddr);
            chk($sformatf("v%0d_cnt", i), {28'h0, wr_count}, {28'h0, vecs[i].exp_cnt});
        end

        // Counter wrap: fresh reset, then 17 legal stores.
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            store_word(32'h80, 32'h100 + i);
            if (i == 15) chk("wrap_15", {28'h0, wr_count}, 32'hF);
            if (i == 16) chk("wrap_16", {28'h0, wr_count}, 32'h0);
            if (i == 17) chk("wrap_17", {28'h0, wr_count}, 32'h1);
        end
        @(negedge clk);
        d_rd_en = 1'b1; dAddr = 32'h80; load_size = 2'b10;
        #1;
        chk("wrap_data", dRdata, 32'h111);
        @(negedge clk);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory stage directly downstream of the single-cycle CPU core's data port.
- Consumes the core's d_wr_en, dAddr, dWdata, store_size and load_size, plus a load-unsigned qualifier and a read strobe.
- Returns dRdata to the core in the same cycle.
- Holds a byte-laned synchronous-write RAM with combinational read, sign/zero extension, misalignment and illegal-size detection, a sticky error capture, and a committed-write counter.

Parameters:
ADDR_WIDTH, 8, word-address bits; depth = 2^ADDR_WIDTH 32-bit words (default 1 KiB)
CNT_WIDTH, 16, width of the committed-write counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
d_wr_en  input  1  store request this cycle
d_rd_en  input  1  load request this cycle
dAddr  input  32  byte address; word index = dAddr[ADDR_WIDTH+1:2], upper bits ignored (aliasing)
dWdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
store_size  input  2  00 byte, 01 half, 10 word, 11 illegal
load_size  input  2  00 byte, 01 half, 10 word, 11 illegal
load_uns  input  1  1 = zero-extend byte/half loads, 0 = sign-extend
dRdata  output  32  load result, combinational
err_flag  output  1  sticky access-error flag
err_addr  output  32  dAddr of the first error since last clear
err_clr  input  1  synchronous clear of err_flag and err_addr
wr_count  output  CNT_WIDTH  number of committed stores, wraps

Behaviour:
- Reset (rst=0, asynchronous):
  - err_flag=0, err_addr=0, wr_count=0.
  - RAM contents are not reset; simulation initialises them to 0.
- Reset release is synchronous to clk. No request is honoured on the edge where rst is low.
- Store (rising edge, d_wr_en=1, legal access):
  - byte: lane dAddr[1:0] <= dWdata[7:0].
  - half: lanes {dAddr[1],0} and {dAddr[1],1} <= dWdata[15:0], little-endian.
  - word: all four lanes <= dWdata.
  - Other lanes are untouched.
  - wr_count increments by 1 and wraps from all-ones to 0.
- Load (combinational):
  - Selects the byte or half from the addressed word by dAddr low bits.
  - Extends to 32 bits: sign-extend if load_uns=0, zero-extend if load_uns=1. load_uns is ignored for word loads.
  - dRdata=0 when d_rd_en=0, when load_size=11, or when the load is a rejected misaligned access.
  - A load to the word being stored in the same cycle returns the old contents (the write lands at the edge).
- Illegal size (11):
  - On a store with d_wr_en=1: no write, wr_count unchanged, error raised.
  - On a load with d_rd_en=1: dRdata=0, error raised.
- Error capture (rising edge):
  - If an error occurs and err_flag=0: err_flag <= 1, err_addr <= dAddr.
  - If err_flag=1, later errors do not overwrite err_addr.
  - err_clr=1 with no error that cycle: both registers cleared.
  - err_clr=1 and a new error in the same cycle: the new error wins (err_flag=1, err_addr = new dAddr).
- Simultaneous d_wr_en=1 and d_rd_en=1:
  - Both are honoured: the load returns old data, the store commits at the edge.
  - If both are in error, a single error is captured with the shared dAddr.
- Latency:
  - Load data is valid in the same cycle as the request (zero wait).
  - Store data is visible to loads from the next cycle.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined:
  - Half with dAddr[0]=1, or word with dAddr[1:0]!=00, is an error.
  - A misaligned store is suppressed (no lanes written, wr_count unchanged).
  - A misaligned load returns 0.
  - Either case raises the error capture.
- Undefined:
  - No misalignment detection. Low bits are truncated: half uses dAddr[1] only, word ignores dAddr[1:0].
  - The access completes normally.
  - Illegal-size (11) errors are still raised.

Test Plan:
- Reset: hold rst=0, drive a store of word 0xDEADBEEF to 0x10 -> no write; err_flag=0, err_addr=0, wr_count=0 during and after reset.
- Byte/half stores, sign/zero extension:
  - Store word 0x11223344 @0x20, then byte 0xAA @0x21.
  - Word load @0x20 -> 0x1122AA44; wr_count=2.
  - Byte load @0x21, load_uns=0 -> 0xFFFFFFAA; load_uns=1 -> 0x000000AA.
  - Half load @0x22, load_uns=0 -> 0x00001122.
- Read-during-write: @0x30 holds 0x0; same cycle store 0x55 and word load @0x30 -> dRdata=0x00000000 that cycle, 0x00000055 next cycle.
- Misalignment with DMEM_MISALIGN_TRAP_EN:
  - Word store 0xCAFEF00D @0x42 -> memory @0x40 unchanged, wr_count unchanged, err_flag=1, err_addr=0x42.
  - A following half load @0x45 -> dRdata=0, err_addr stays 0x42.
- Misalignment without DMEM_MISALIGN_TRAP_EN: word store 0xCAFEF00D @0x42 -> word load @0x40 returns 0xCAFEF00D, err_flag=0.
- Error clear priority:
  - err_clr=1 alone -> err_flag=0, err_addr=0 next cycle.
  - err_clr=1 with a load_size=11 load @0x7C the same cycle -> err_flag=1, err_addr=0x7C.
- Counter wrap: with CNT_WIDTH=4, perform 17 legal stores -> wr_count reads 0xF after 15 stores, 0x0 after 16, 0x1 after 17.
